// File: rtl/counter_game_driver_if.sv
// Host + counter side signal bundle for counter_game_driver.
// slave = driver view, master = host/counter view.
interface counter_game_driver_if #(
    parameter int CNT_SIZE   = 5,
    parameter int SCORE_SIZE = 4,
    parameter int CYCLE_W    = 16
);
    // host configuration / control
    logic                  start;
    logic [1:0]            cfg_mode;
    logic                  cfg_load;
    logic [CNT_SIZE-1:0]   cfg_value;
    logic                  abort;
    logic                  busy;
    // counter drive
    logic [1:0]            mode;
    logic                  init;
    logic [CNT_SIZE-1:0]   init_value;
    // counter observation
    logic                  winner;
    logic                  loser;
    logic                  gameover;
    logic [1:0]            who;
    // result record
    logic                  res_valid;
    logic                  res_ready;
    logic [1:0]            res_who;
    logic [CYCLE_W-1:0]    res_cycles;
    logic [SCORE_SIZE-1:0] res_wins;
    logic [SCORE_SIZE-1:0] res_losses;
    logic                  res_timeout;
    logic                  res_mismatch;

    modport slave (
        input  start, cfg_mode, cfg_load, cfg_value, abort,
        input  winner, loser, gameover, who, res_ready,
        output busy, mode, init, init_value,
        output res_valid, res_who, res_cycles, res_wins, res_losses,
        output res_timeout, res_mismatch
    );

    modport master (
        output start, cfg_mode, cfg_load, cfg_value, abort,
        output winner, loser, gameover, who, res_ready,
        input  busy, mode, init, init_value,
        input  res_valid, res_who, res_cycles, res_wins, res_losses,
        input  res_timeout, res_mismatch
    );
endinterface

// File: rtl/counter_game_driver.sv
// Closed-loop driver and shadow scoreboard for the 5-bit counter game.
// Define GAME_DRIVER_TIMEOUT_EN to end RUN after TIMEOUT cycles without gameover.
module counter_game_driver #(
    parameter int CNT_SIZE   = 5,
    parameter int SCORE_SIZE = 4,
    parameter int CYCLE_W    = 16
`ifdef GAME_DRIVER_TIMEOUT_EN
    , parameter int TIMEOUT  = 1000
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_game_driver_if.slave  gd_io
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_e;

    localparam logic [SCORE_SIZE-1:0] SMAX = '1;
    localparam logic [CYCLE_W-1:0]    CMAX = '1;

    state_e state_q, state_d;

    logic [1:0]            mode_q,     mode_d;
    logic [CNT_SIZE-1:0]   value_q,    value_d;
    logic [CYCLE_W-1:0]    cycles_q,   cycles_d;
    logic [SCORE_SIZE-1:0] wins_q,     wins_d;
    logic [SCORE_SIZE-1:0] losses_q,   losses_d;
    logic [1:0]            who_q,      who_d;
    logic                  timeout_q,  timeout_d;
    logic                  mismatch_q, mismatch_d;

    // Values the counters take if this RUN edge is counted.
    logic [CYCLE_W-1:0]    cycles_inc;
    logic [SCORE_SIZE-1:0] wins_inc;
    logic [SCORE_SIZE-1:0] losses_inc;
    logic [1:0]            verdict;
    logic                  timeout_hit;

    assign cycles_inc = (cycles_q == CMAX) ? cycles_q : cycles_q + 1'b1;
    assign wins_inc   = (gd_io.winner && wins_q != SMAX) ? wins_q + 1'b1 : wins_q;
    assign losses_inc = (gd_io.loser && losses_q != SMAX) ? losses_q + 1'b1 : losses_q;

    // Shadow verdict uses the scores including the ending edge.
    always_comb begin
        verdict = 2'b00;
        if (wins_inc == SMAX)
            verdict = 2'b10;
        else if (losses_inc == SMAX)
            verdict = 2'b01;
    end

`ifdef GAME_DRIVER_TIMEOUT_EN
    assign timeout_hit = (cycles_inc == CYCLE_W'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (gd_io.start)
                    state_d = gd_io.cfg_load ? S_LOAD : S_RUN;
            end
            S_LOAD: begin
                state_d = gd_io.abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (gd_io.abort)
                    state_d = S_IDLE;
                else if (gd_io.gameover || timeout_hit)
                    state_d = S_REPORT;
            end
            S_REPORT: begin
                if (gd_io.res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        gd_io.busy         = (state_q != S_IDLE);
        gd_io.init         = (state_q == S_LOAD);
        gd_io.res_valid    = (state_q == S_REPORT);
        gd_io.mode         = mode_q;
        gd_io.init_value   = value_q;
        gd_io.res_who      = who_q;
        gd_io.res_cycles   = cycles_q;
        gd_io.res_wins     = wins_q;
        gd_io.res_losses   = losses_q;
        gd_io.res_timeout  = timeout_q;
        gd_io.res_mismatch = mismatch_q;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        mode_d     = mode_q;
        value_d    = value_q;
        cycles_d   = cycles_q;
        wins_d     = wins_q;
        losses_d   = losses_q;
        who_d      = who_q;
        timeout_d  = timeout_q;
        mismatch_d = mismatch_q;
        case (state_q)
            S_IDLE: begin
                if (gd_io.start) begin
                    mode_d     = gd_io.cfg_mode;
                    value_d    = gd_io.cfg_value;
                    cycles_d   = '0;
                    wins_d     = '0;
                    losses_d   = '0;
                    who_d      = 2'b00;
                    timeout_d  = 1'b0;
                    mismatch_d = 1'b0;
                end
            end
            S_RUN: begin
                // An aborted game produces no result, so its last edge is not scored.
                if (!gd_io.abort) begin
                    cycles_d = cycles_inc;
                    wins_d   = wins_inc;
                    losses_d = losses_inc;
                    if (gd_io.gameover) begin
                        who_d      = gd_io.who;
                        mismatch_d = (verdict != gd_io.who);
                    end else if (timeout_hit) begin
                        who_d      = 2'b00;
                        timeout_d  = 1'b1;
                        mismatch_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= 2'b00;
            value_q    <= '0;
            cycles_q   <= '0;
            wins_q     <= '0;
            losses_q   <= '0;
            who_q      <= 2'b00;
            timeout_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            value_q    <= value_d;
            cycles_q   <= cycles_d;
            wins_q     <= wins_d;
            losses_q   <= losses_d;
            who_q      <= who_d;
            timeout_q  <= timeout_d;
            mismatch_q <= mismatch_d;
        end
    end

endmodule

// File: tb/tb_counter_game_driver.sv
// Directed bench for counter_game_driver: reference counter model, forced-outcome
// vector table, and hand sequences for preload, handshake, abort, reset, timeout.
module tb_counter_game_driver;

    logic clk;
    logic rst;

    counter_game_driver_if bus ();

`ifdef GAME_DRIVER_TIMEOUT_EN
    counter_game_driver #(.CNT_SIZE(5), .SCORE_SIZE(4), .CYCLE_W(16), .TIMEOUT(20))
        dut (.clk(clk), .rst(rst), .gd_io(bus));
`else
    counter_game_driver #(.CNT_SIZE(5), .SCORE_SIZE(4), .CYCLE_W(16))
        dut (.clk(clk), .rst(rst), .gd_io(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference counter model ----------------
    logic [4:0]  m_c;
    logic [3:0]  m_w, m_l;
    logic [15:0] m_cyc;
    logic        m_done, m_clr;
    logic        m_win, m_los, m_go;
    logic [1:0]  m_who;

    assign m_win = (m_c == 5'd31);
    assign m_los = (m_c == 5'd0);
    assign m_go  = (m_w == 4'd15) || (m_l == 4'd15);
    assign m_who = (m_w == 4'd15) ? 2'b10 : (m_l == 4'd15) ? 2'b01 : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_c <= '0; m_w <= '0; m_l <= '0; m_cyc <= '0; m_done <= 1'b0;
        end else begin
            if (bus.init)
                m_c <= bus.init_value;
            else
                case (bus.mode)
                    2'b00: m_c <= m_c + 5'd1;
                    2'b01: m_c <= m_c + 5'd2;
                    2'b10: m_c <= m_c - 5'd1;
                    default: m_c <= m_c - 5'd2;
                endcase
            if (m_clr) begin
                m_w <= '0; m_l <= '0; m_cyc <= '0; m_done <= 1'b0;
            end else begin
                if (!m_go) begin
                    if (m_win) m_w <= m_w + 4'd1;
                    if (m_los) m_l <= m_l + 4'd1;
                end
                if (!m_done) begin
                    m_cyc <= m_cyc + 16'd1;
                    if (m_go) m_done <= 1'b1;
                end
            end
        end
    end

    // Counter-side inputs: model outputs, or forced values for directed games.
    logic       ovr, ov_win, ov_los, ov_go;
    logic [1:0] ov_who;
    assign bus.winner   = ovr ? ov_win : m_win;
    assign bus.loser    = ovr ? ov_los : m_los;
    assign bus.gameover = ovr ? ov_go  : m_go;
    assign bus.who      = ovr ? ov_who : m_who;

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic start_game(input logic [1:0] md, input logic ld, input logic [4:0] val);
        bus.start = 1'b1; bus.cfg_mode = md; bus.cfg_load = ld; bus.cfg_value = val;
        m_clr = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.cfg_mode = 2'b00; bus.cfg_load = 1'b0; bus.cfg_value = '0;
        m_clr = 1'b0;
    endtask

    task automatic take_result();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mode;
        int         n_win;
        int         n_los;
        logic       win_end;
        logic [1:0] who;
        logic [1:0] e_who;
        int         e_cyc;
        int         e_wins;
        int         e_los;
        logic       e_mis;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // mode, wins, losses, winner@end, who | who, cycles, wins, losses, mismatch
        vecs[0] = '{2'b00,  3,  0, 1'b0, 2'b10, 2'b10,  4,  3,  0, 1'b1};
        vecs[1] = '{2'b01, 14,  2, 1'b1, 2'b10, 2'b10, 17, 15,  2, 1'b0};
        vecs[2] = '{2'b10,  0, 15, 1'b0, 2'b01, 2'b01, 16,  0, 15, 1'b0};
        vecs[3] = '{2'b11, 17, 16, 1'b0, 2'b01, 2'b01, 34, 15, 15, 1'b1};
        vecs[4] = '{2'b00,  0,  0, 1'b0, 2'b00, 2'b00,  1,  0,  0, 1'b0};
        vecs[5] = '{2'b01,  2,  1, 1'b1, 2'b11, 2'b11,  4,  3,  1, 1'b1};

        rst = 1'b1;
        bus.start = 1'b0; bus.cfg_mode = '0; bus.cfg_load = 1'b0; bus.cfg_value = '0;
        bus.abort = 1'b0; bus.res_ready = 1'b0;
        m_clr = 1'b0;
        ovr = 1'b0; ov_win = 1'b0; ov_los = 1'b0; ov_go = 1'b0; ov_who = 2'b00;

        // ---- reset state ----
        #1;
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_init",      32'(bus.init), 0);
        chk("rst_mode",      32'(bus.mode), 0);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_res_cyc",   32'(bus.res_cycles), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---- closed-loop game against the reference model, up-by-1 ----
        start_game(2'b00, 1'b0, 5'd0);
        chk("model_busy", 32'(bus.busy), 1);
        begin
            int k = 0;
            while (!bus.res_valid && k < 2000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("model_done",     32'(bus.res_valid), 1);
        chk("model_who",      32'(bus.res_who), 32'(m_who));
        chk("model_mismatch", 32'(bus.res_mismatch), 0);
        chk("model_cycles",   32'(bus.res_cycles), 32'(m_cyc));
        take_result();
        chk("model_idle", 32'(bus.busy), 0);

        // ---- preload: mode 11 from 18 ----
        start_game(2'b11, 1'b1, 5'b10010);
        chk("pre_init1",  32'(bus.init), 1);
        chk("pre_value",  32'(bus.init_value), 18);
        chk("pre_mode",   32'(bus.mode), 3);
        @(negedge clk);
        chk("pre_init0",  32'(bus.init), 0);
        chk("pre_cnt18",  32'(m_c), 18);
        @(negedge clk);
        chk("pre_cnt16",  32'(m_c), 16);
        chk("pre_init0b", 32'(bus.init), 0);
        @(negedge clk);
        chk("pre_cnt14",  32'(m_c), 14);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("pre_abort_busy",  32'(bus.busy), 0);
        chk("pre_abort_valid", 32'(bus.res_valid), 0);

        // ---- forced-outcome vector table ----
        ovr = 1'b1;
        for (int v = 0; v < 6; v++) begin
            start_game(vecs[v].mode, 1'b0, 5'd0);
            chk($sformatf("v%0d_mode", v), 32'(bus.mode), 32'(vecs[v].mode));
            for (int k = 0; k < vecs[v].n_win; k++) begin
                ov_win = 1'b1;
                @(negedge clk);
            end
            ov_win = 1'b0;
            for (int k = 0; k < vecs[v].n_los; k++) begin
                ov_los = 1'b1;
                @(negedge clk);
            end
            ov_los = 1'b0;
            ov_go = 1'b1; ov_who = vecs[v].who; ov_win = vecs[v].win_end;
            @(negedge clk);
            ov_go = 1'b0; ov_who = 2'b00; ov_win = 1'b0;
            chk($sformatf("v%0d_valid", v),    32'(bus.res_valid), 1);
            chk($sformatf("v%0d_who", v),      32'(bus.res_who), 32'(vecs[v].e_who));
            chk($sformatf("v%0d_cycles", v),   32'(bus.res_cycles), 32'(vecs[v].e_cyc));
            chk($sformatf("v%0d_wins", v),     32'(bus.res_wins), 32'(vecs[v].e_wins));
            chk($sformatf("v%0d_losses", v),   32'(bus.res_losses), 32'(vecs[v].e_los));
            chk($sformatf("v%0d_mismatch", v), 32'(bus.res_mismatch), 32'(vecs[v].e_mis));
            chk($sformatf("v%0d_timeout", v),  32'(bus.res_timeout), 0);
            take_result();
            chk($sformatf("v%0d_drop", v), 32'(bus.res_valid), 0);
        end

        // ---- handshake hold with start/abort pulses during REPORT ----
        start_game(2'b00, 1'b0, 5'd0);
        ov_go = 1'b1; ov_los = 1'b1; ov_who = 2'b01;
        @(negedge clk);
        ov_go = 1'b0; ov_los = 1'b0; ov_who = 2'b00;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hs%0d_valid", c),  32'(bus.res_valid), 1);
            chk($sformatf("hs%0d_who", c),    32'(bus.res_who), 1);
            chk($sformatf("hs%0d_cycles", c), 32'(bus.res_cycles), 1);
            chk($sformatf("hs%0d_losses", c), 32'(bus.res_losses), 1);
            chk($sformatf("hs%0d_mis", c),    32'(bus.res_mismatch), 1);
            bus.start = (c == 1); bus.cfg_mode = 2'b10; bus.cfg_load = 1'b1;
            bus.abort = (c == 2);
            @(negedge clk);
        end
        bus.start = 1'b0; bus.cfg_mode = 2'b00; bus.cfg_load = 1'b0; bus.abort = 1'b0;
        chk("hs_hold_valid", 32'(bus.res_valid), 1);
        take_result();
        chk("hs_drop_valid", 32'(bus.res_valid), 0);
        chk("hs_drop_busy",  32'(bus.busy), 0);
        chk("hs_mode_kept",  32'(bus.mode), 0);
        @(negedge clk);
        chk("hs_no_restart", 32'(bus.busy), 0);

        // ---- abort on the 7th RUN edge, coinciding with gameover ----
        start_game(2'b10, 1'b0, 5'd0);
        repeat (6) @(negedge clk);
        chk("ab_still_busy", 32'(bus.busy), 1);
        bus.abort = 1'b1; ov_go = 1'b1; ov_who = 2'b10;
        @(negedge clk);
        bus.abort = 1'b0; ov_go = 1'b0; ov_who = 2'b00;
        chk("ab_busy",   32'(bus.busy), 0);
        chk("ab_valid",  32'(bus.res_valid), 0);
        @(negedge clk);
        chk("ab_valid2", 32'(bus.res_valid), 0);

`ifdef GAME_DRIVER_TIMEOUT_EN
        // ---- timeout after 20 RUN cycles ----
        start_game(2'b00, 1'b0, 5'd0);
        repeat (19) @(negedge clk);
        chk("to_not_yet", 32'(bus.res_valid), 0);
        @(negedge clk);
        chk("to_valid",   32'(bus.res_valid), 1);
        chk("to_flag",    32'(bus.res_timeout), 1);
        chk("to_who",     32'(bus.res_who), 0);
        chk("to_cycles",  32'(bus.res_cycles), 20);
        chk("to_mis",     32'(bus.res_mismatch), 0);
        take_result();
`endif

        // ---- asynchronous reset in RUN ----
        start_game(2'b01, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        chk("rr_cycles_pre", 32'(bus.res_cycles), 3);
        #2 rst = 1'b1;
        #1;
        chk("rr_busy",   32'(bus.busy), 0);
        chk("rr_mode",   32'(bus.mode), 0);
        chk("rr_init",   32'(bus.init), 0);
        chk("rr_ival",   32'(bus.init_value), 0);
        chk("rr_valid",  32'(bus.res_valid), 0);
        chk("rr_cycles", 32'(bus.res_cycles), 0);
        chk("rr_who",    32'(bus.res_who), 0);
        chk("rr_scores", 32'({bus.res_wins, bus.res_losses, bus.res_timeout, bus.res_mismatch}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rr_idle", 32'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/counter_game_driver.md
# counter_game_driver

Closed-loop driver and scoreboard for the 5-bit multi-mode counter game. It accepts a game configuration from a host: counting mode, optional preload value and whether to preload. It then drives the counter's `mode`/`init`/`initialValue` inputs and watches the counter's `winner`/`loser`/`GAMEOVER`/`who` outputs. At the end of the game it returns a result record over a valid/ready handshake. It sits between the host/test sequencer and the counter, and independently cross-checks the counter's scorekeeping.

## Interface
- `CNT_SIZE`, 5, counter width; must match the counter instance
- `SCORE_SIZE`, 4, shadow score counter width; max = 2^SCORE_SIZE-1
- `CYCLE_W`, 16, game cycle counter width
- `TIMEOUT`, 1000, RUN cycles before forced end (timeout build only)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin game; sampled only in IDLE
- `cfg_mode`  in  2  counting mode, captured at start
- `cfg_load`  in  1  1 = preload before counting, captured at start
- `cfg_value`  in  CNT_SIZE  preload value, captured at start
- `abort`  in  1  cancel the active game
- `busy`  out  1  high in every state except IDLE
- `mode`  out  2  to counter `mode`
- `init`  out  1  to counter `init`
- `init_value`  out  CNT_SIZE  to counter `initialValue`
- `winner`, `loser`, `gameover`  in  1 each  from counter
- `who`  in  2  from counter
- `res_valid`  out  1  result available
- `res_ready`  in  1  host accepts result
- `res_who`  out  2  counter `who` at end of game (00 on timeout)
- `res_cycles`  out  CYCLE_W  RUN cycles elapsed; saturates at all-ones
- `res_wins`, `res_losses`  out  SCORE_SIZE  shadow scores
- `res_timeout`  out  1  game ended by timeout
- `res_mismatch`  out  1  shadow verdict differs from `res_who`

## Operation
- States: IDLE, LOAD, RUN, REPORT.
- **IDLE:** `init`=0, `mode` holds its last value. On `start`=1, capture the configuration, clear cycle/win/loss counters, and go to LOAD if `cfg_load`, else RUN.
- **LOAD:** lasts exactly one cycle.
  - Outputs: `init`=1, `init_value`=captured value.
  - Next state: RUN, or IDLE if `abort`=1.
- **RUN:**
  - Outputs: `init`=0, `mode`=captured mode.
  - Every cycle: increment `res_cycles`.
  - `winner`=1 sampled → wins+1; `loser`=1 sampled → losses+1; both saturate at max.
- **RUN exits:**
  - `gameover`=1 sampled → capture `who` into `res_who`, go to REPORT.
  - `abort`=1 → IDLE with no result; this takes priority over `gameover`.
  - Timeout (see Configuration) → REPORT with `res_timeout`=1 and `res_who`=00.
- **Shadow verdict:** wins==max → 10; else losses==max → 01; else 00. `res_mismatch` = (verdict != `res_who`), computed on REPORT entry; forced 0 on timeout.
- **REPORT:** `res_valid`=1. All `res_*` outputs stay stable until `res_ready`=1, then go to IDLE. `abort` is ignored in REPORT.
- **Ignored inputs:** `start` is ignored outside IDLE. `cfg_*` is ignored except at start.

## Timing
- **Reset** (any state, async): state IDLE.
  - Outputs: `busy`, `init`, `mode`, `init_value`, `res_valid` and all `res_*` = 0.
  - A reset mid-game discards the game.
- **Start latency:**
  - `start` at edge N → `busy`=1 after N.
  - Load games: `init`=1 for cycle N..N+1 only, so the counter loads at edge N+1; RUN starts after N+1.
  - No-load games: RUN starts after N.
- **`res_cycles`:** counts RUN edges, including the edge that samples `gameover`.
- **Handshake:** `res_valid` rises the cycle after the ending edge. A transfer happens on any edge where `res_valid` & `res_ready`. `res_valid` falls the next cycle. `res_ready` while `res_valid`=0 has no effect.
- **Back-to-back games:** earliest restart is a `start` in the first IDLE cycle after a transfer.
- **Simultaneous events on one RUN edge:**
  - `winner` and `gameover`: the win is counted and the game ends.
  - `abort` and `gameover`: abort wins.
  - `abort` and timeout: abort wins.

## Configuration
- `GAME_DRIVER_TIMEOUT_EN` defined: a RUN game ends when `res_cycles` reaches `TIMEOUT` without `gameover`.
- `GAME_DRIVER_TIMEOUT_EN` undefined: no timeout logic; `res_timeout` is tied to 0 and RUN lasts until `gameover` or `abort`.

## Test plan
- **No-load, up-by-1:** reset, `start` with `cfg_mode`=00, `cfg_load`=0, driving a reference counter model → `res_who` equals the model's `who`, `res_mismatch`=0, and `res_cycles` equals the model's cycle count to GAMEOVER.
- **Preload:** `cfg_load`=1, `cfg_value`=5'b10010, `cfg_mode`=11 → `init`=1 for exactly one cycle with `init_value`=18; the counter shows 18 the next cycle, then 16, 14, …
- **Timeout** (macro defined, `TIMEOUT`=20): hold `gameover`=0 → after 20 RUN cycles `res_valid`=1, `res_timeout`=1, `res_who`=00, `res_cycles`=20.
- **Handshake hold:** hold `res_ready`=0 for 5 cycles in REPORT → all `res_*` stay stable; `res_ready`=1 → `res_valid`=0 next cycle; a `start` pulsed during REPORT is ignored.
- **Mismatch:** force `gameover`=1, `who`=10 while shadow wins=3 → `res_mismatch`=1, `res_who`=10.
- **Abort/reset:** `abort` in cycle 7 of RUN → IDLE, no `res_valid`. In a second game, assert `rst` in RUN → all outputs 0 immediately.
